// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M MUL/DIV/DIVU/REM/REMU unit beside the execute-stage ALU.
// Latency: start accepted in cycle 0 -> done in cycle XLEN+2; divide-by-zero/overflow -> done in cycle 1.
// Backpressure: accepts only while ready (IDLE/DONE); start while busy is dropped; flush aborts to IDLE.
// Ports: clk, rst (async, active-high); start/funct3/op_a/op_b request; flush abort;
//        ready/busy/done status decoded from the state register; result held until next accept.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;      // latched funct3
  logic [XLEN-1:0] a_q;     // multiplicand, or quotient/dividend shift register
  logic [XLEN-1:0] b_q;     // multiplier, or divisor magnitude
  logic [XLEN-1:0] acc;     // product accumulator, or partial remainder
  logic            neg_q;
  logic            neg_r;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? -x : x;
  endfunction

  // Decode of the incoming request
  logic in_div, in_sgn, in_rem, in_dz, in_ovf;
  assign in_div = funct3[2];
  assign in_sgn = funct3[2] & ~funct3[0];
  assign in_rem = funct3[1];
  assign in_dz  = in_div && (op_b == '0);
  assign in_ovf = in_sgn && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  // Restoring-divide step. The partial remainder is always below the divisor,
  // so the shifted value is below 2*divisor and the XLEN+1 bit difference
  // cannot wrap: its top bit is exactly the borrow, i.e. (rem < divisor).
  logic [XLEN:0] rem_sh, diff;
  assign rem_sh = {acc, a_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, b_q};

  logic [XLEN-1:0] fix_val;
  always_comb begin
    fix_val = acc;
    if (op[2]) begin
      if (op[1]) fix_val = neg_r ? -acc : acc;
      else       fix_val = neg_q ? -a_q : a_q;
    end
  end

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == CALC) || (state == FIX);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op    <= funct3;
            cnt   <= '0;
            acc   <= '0;
            neg_q <= in_sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_r <= in_sgn & op_a[XLEN-1];
            a_q   <= in_sgn ? mag(op_a) : op_a;
            b_q   <= in_sgn ? mag(op_b) : op_b;
            if (in_dz) begin
              result <= in_rem ? op_a : '1;
              state  <= DONE;
            end else if (in_ovf) begin
              result <= in_rem ? '0 : op_a;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (op[2]) begin
            if (!diff[XLEN]) begin
              acc <= diff[XLEN-1:0];
              a_q <= {a_q[XLEN-2:0], 1'b1};
            end else begin
              acc <= rem_sh[XLEN-1:0];
              a_q <= {a_q[XLEN-2:0], 1'b0};
            end
          end else begin
            if (b_q[0]) acc <= acc + a_q;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M operations MUL, DIV, DIVU, REM and REMU, sitting beside the single-cycle ALU in the execute stage. It accepts one operation at a time through a start/busy/done handshake and runs a 32-step shift-add or restoring-divide loop. While running, it holds the pipeline stall request high. It handles sign correction and the RISC-V divide-by-zero and overflow corner cases with fixed results.

## Interface
- XLEN, 32: operand and result width; the iteration count equals XLEN.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only when ready=1.
- funct3  in  3  000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; any other code is treated as MUL.
- op_a  in  XLEN  multiplicand or dividend; captured on accept.
- op_b  in  XLEN  multiplier or divisor; captured on accept.
- flush  in  1  abort the in-flight operation (branch mispredict).
- ready  out  1  high in IDLE and DONE.
- busy  out  1  high in CALC and FIX; drives the pipeline stall.
- done  out  1  one-cycle pulse in DONE.
- result  out  XLEN  final value; held until the next accept.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch operands and funct3, and clear the step counter.
  - If the op is a divide/remainder and op_b=0, load the special result and go to DONE. DIV/DIVU give all ones; REM/REMU give op_a.
  - If the op is DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF, load the special result and go to DONE. DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC.
- IDLE/DONE with start=0: DONE goes to IDLE; IDLE stays.
- Signed ops (DIV/REM):
  - Operands are converted to magnitudes on accept.
  - The quotient is negated in FIX when sign(a) differs from sign(b).
  - The remainder is negated in FIX when sign(a)=1.
- MUL: unsigned shift-add on the raw operands; result is the low XLEN bits of the product (sign-independent).
- CALC, one step per cycle:
  - MUL: if the multiplier LSB is 1, accumulator += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
  - Divide: shift {rem,quo} left by 1. If rem >= divisor, set rem -= divisor and quo[0]=1.
  - All arithmetic is XLEN-bit modulo 2^XLEN, except the divide compare, which uses XLEN+1 bits.
- CALC exits to FIX after step counter value XLEN-1, i.e. after exactly XLEN steps.
- FIX: apply sign correction and select quotient, remainder or product into result; go to DONE.
- flush=1 in any state:
  - The next state is IDLE and done stays 0.
  - result is unchanged.
  - flush overrides start in the same cycle.
- start while busy=1 is ignored; there is no queueing.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, result=0, counter=0, internal registers 0.
- Normal op, with start accepted in cycle 0:
  - busy=1 in cycles 1..XLEN+1 (CALC for XLEN cycles, then FIX).
  - done=1 and result valid in cycle XLEN+2, i.e. cycle 34 for XLEN=32.
- Special case (divide-by-zero or overflow): done=1 in cycle 1 and busy never rises.
- Back-to-back: start asserted during DONE is accepted. done pulses for that cycle only, and busy=1 from the next cycle.
- All outputs are registered; done and busy are decoded from the registered state only.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous), with no done pulse. Operation resumes on the first clk edge after deassertion, in IDLE.

## Test plan
- MUL op_a=7, op_b=6 -> busy cycles 1-33, done at cycle 34, result=42; then MUL 0xFFFFFFFF×0xFFFFFFFF -> result=1.
- DIV op_a=-7 (0xFFFFFFF9), op_b=2 -> result 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done at cycle 1 with 0xFFFFFFFF and busy=0 throughout; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1.
- flush asserted at cycle 10 of a DIVU -> IDLE at cycle 11, no done pulse, result keeps its previous value. A start during the busy window is ignored and produces no extra done.
- Back-to-back: MUL 3×4 then a start held during its DONE cycle with DIVU 9/3. Required: first result=12 at cycle 34, second result=3 at cycle 68, each done pulse exactly 1 cycle.
- rst asserted asynchronously mid-CALC -> busy=0, done=0, result=0 before the next clk edge. A subsequent MUL 2×3 -> 6 with normal latency.
